// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: FUNCT3 encodings,
// FSM state encoding and the lane/alignment helper functions.
package mem_access_unit_pkg;

  // FUNCT3 encodings of the RV32I loads and stores
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size field (FUNCT3[1:0]); 1x is a word
  localparam logic [1:0] SZ_BYTE = F3_LB[1:0];
  localparam logic [1:0] SZ_HALF = F3_LH[1:0];

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Naturally aligned check for the given access size and byte offset
  function automatic logic access_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~off[0];
      default: return (off == 2'b00);
    endcase
  endfunction

  // Byte-lane enables of the accessed bytes within the word
  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated into every lane so the enabled lane carries it
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// Combinational load extractor: selects the addressed byte/half of the
// memory word and sign- or zero-extends it to 32 bits.
module mem_access_unit_load_extender
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_ext;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lanes[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lanes[offset];
  assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  assign sign_ext = ~funct3[2];

  // Extend the selected field according to size and signedness
  always_comb begin
    data = rdata;
    case (funct3[1:0])
      SZ_BYTE: data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one byte-enabled word request per
// load/store, stalls the pipeline while memory is busy and returns the
// extended load data.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] DMEM_ADDR,
  output logic        DMEM_READ,
  output logic        DMEM_WRITE,
  output logic [31:0] DMEM_WDATA,
  output logic [3:0]  DMEM_BYTEEN,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_BUSYWAIT,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT,
  output logic        MISALIGNED
);

  state_t      state_reg;
  logic        op_read_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  offset_reg;

  logic        req;
  logic        aligned;
  logic        start;
  logic [31:0] load_ext;

  assign req     = MEM_READ | MEM_WRITE;
  assign aligned = access_aligned(FUNCT3[1:0], ADDRESS[1:0]);
  assign start   = (state_reg == ST_IDLE) & req & aligned;

  // Stall covers the request cycle and every cycle the access is in flight
  assign BUSYWAIT   = ~RESET & (start | (state_reg == ST_ACCESS));
  assign MISALIGNED = ~RESET & (state_reg == ST_IDLE) & req & ~aligned;

  // Extraction uses the latched size/offset so inputs may change meanwhile
  mem_access_unit_load_extender u_load_extender (
    .rdata  (DMEM_RDATA),
    .offset (offset_reg),
    .funct3 (funct3_reg),
    .data   (load_ext)
  );

  // Access FSM with registered memory strobes and load result
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= ST_IDLE;
      op_read_reg <= 1'b0;
      funct3_reg  <= 3'b000;
      offset_reg  <= 2'b00;
      DMEM_ADDR   <= 32'h0;
      DMEM_READ   <= 1'b0;
      DMEM_WRITE  <= 1'b0;
      DMEM_WDATA  <= 32'h0;
      DMEM_BYTEEN <= 4'b0000;
      READ_DATA   <= 32'h0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            // A simultaneous read and write request is treated as a read
            DMEM_ADDR   <= {ADDRESS[31:2], 2'b00};
            DMEM_WDATA  <= store_lanes(FUNCT3[1:0], WRITE_DATA);
            DMEM_BYTEEN <= lane_enables(FUNCT3[1:0], ADDRESS[1:0]);
            DMEM_READ   <= MEM_READ;
            DMEM_WRITE  <= ~MEM_READ;
            op_read_reg <= MEM_READ;
            funct3_reg  <= FUNCT3;
            offset_reg  <= ADDRESS[1:0];
            state_reg   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!DMEM_BUSYWAIT) begin
            DMEM_READ  <= 1'b0;
            DMEM_WRITE <= 1'b0;
            if (op_read_reg) begin
              READ_DATA <= load_ext;
            end
            state_reg <= ST_DONE;
          end
        end
        // Inputs still belong to the completing instruction here
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// loads/stores against a byte-level reference memory.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] address, write_data;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, read_data;
  logic        dmem_read, dmem_write, dmem_busywait, busywait, misaligned;
  logic [3:0]  dmem_byteen;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory environment
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  int          lat_cfg = 1;
  int          acc_cnt = 0;
  int          rd_txn  = 0;
  int          wr_txn  = 0;
  logic [31:0] exp_rd  = 32'h0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .CLK           (clk),
    .RESET         (reset),
    .MEM_READ      (mem_read),
    .MEM_WRITE     (mem_write),
    .FUNCT3        (funct3),
    .ADDRESS       (address),
    .WRITE_DATA    (write_data),
    .DMEM_ADDR     (dmem_addr),
    .DMEM_READ     (dmem_read),
    .DMEM_WRITE    (dmem_write),
    .DMEM_WDATA    (dmem_wdata),
    .DMEM_BYTEEN   (dmem_byteen),
    .DMEM_RDATA    (dmem_rdata),
    .DMEM_BUSYWAIT (dmem_busywait),
    .READ_DATA     (read_data),
    .BUSYWAIT      (busywait),
    .MISALIGNED    (misaligned)
  );

  // Memory is busy for the first lat_cfg-1 cycles a strobe is up
  assign dmem_busywait = (dmem_read | dmem_write) && (acc_cnt < lat_cfg - 1);
  assign dmem_rdata    = mem[dmem_addr[9:2]];

  always @(posedge clk) begin
    if (dmem_read | dmem_write) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (!reset && !dmem_busywait) begin
      if (dmem_read) rd_txn <= rd_txn + 1;
      if (dmem_write) begin
        wr_txn <= wr_txn + 1;
        for (int i = 0; i < 4; i++)
          if (dmem_byteen[i]) mem[dmem_addr[9:2]][8*i +: 8] <= dmem_wdata[8*i +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: plain byte arithmetic on the access rules
  function automatic int size_of(input logic [2:0] f3);
    return f3[1] ? 4 : (f3[0] ? 2 : 1);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    int unsigned v;
    int          sz;
    sz = size_of(f3);
    if (sz == 1) begin
      v = (w >> (8 * int'(off))) % 256;
      if (!f3[2] && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = (w >> (16 * int'(off[1]))) % 65536;
      if (!f3[2] && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic go_idle();
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'b0, busywait}, 32'h0);
    check("idle_rdata", read_data, exp_rd);
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input int lat);
    int          sz, base, busy, idx;
    logic        ok_aligned, stable;
    int          rd0, wr0;
    int unsigned be_i, wd_i;
    sz         = size_of(f3);
    ok_aligned = (int'(addr[1:0]) % sz) == 0;
    base       = (int'(addr[1:0]) / sz) * sz;
    idx        = int'(addr[9:2]);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; funct3 = f3; address = addr; write_data = wd;
    lat_cfg = lat;
    rd0 = rd_txn; wr0 = wr_txn;
    @(negedge clk);
    if (!ok_aligned) begin
      $display("access rd=%0b wr=%0b f3=%0d addr=0x%08h misaligned", rd, wr, f3, addr);
      check("mis_flag", {31'b0, misaligned}, 32'h1);
      check("mis_busy", {31'b0, busywait}, 32'h0);
      check("mis_strobe", {30'b0, dmem_read, dmem_write}, 32'h0);
      check("mis_rdata", read_data, exp_rd);
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      check("mis_after", {29'b0, misaligned, dmem_read, dmem_write}, 32'h0);
      return;
    end
    check("req_flags", {30'b0, busywait, misaligned}, 32'h2);
    busy   = 1;
    stable = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busywait) break;
      busy++;
      if (k == 0) begin
        check("strobe", {30'b0, dmem_read, dmem_write}, rd ? 32'h2 : 32'h1);
        check("daddr", dmem_addr, {addr[31:2], 2'b00});
        if (!rd) begin
          be_i = ((1 << sz) - 1) << base;
          wd_i = (sz == 1) ? (wd % 256) * 32'h01010101 :
                 (sz == 2) ? (wd % 65536) * 32'h00010001 : wd;
          check("byteen", {28'b0, dmem_byteen}, be_i);
          check("wdata", dmem_wdata, wd_i);
        end
      end else if ((dmem_read !== rd) || (dmem_write !== !rd)) begin
        stable = 1'b0;
      end
    end
    // Now in the release cycle
    check("stall_cycles", busy, lat + 1);
    check("strobe_hold", {31'b0, stable}, 32'h1);
    check("done_strobe", {30'b0, dmem_read, dmem_write}, 32'h0);
    if (rd) begin
      exp_rd = ref_load(ref_mem[idx], f3, addr[1:0]);
      check("rd_txn", rd_txn - rd0, 1);
      check("wr_txn_none", wr_txn - wr0, 0);
    end else begin
      for (int i = 0; i < sz; i++) ref_mem[idx][8*(base+i) +: 8] = wd[8*i +: 8];
      check("wr_txn", wr_txn - wr0, 1);
      check("rd_txn_none", rd_txn - rd0, 0);
    end
    check("read_data", read_data, exp_rd);
    $display("access rd=%0b wr=%0b f3=%0d addr=0x%08h wd=0x%08h lat=%0d stall=%0d rdata=0x%08h",
             rd, wr, f3, addr, wd, lat, busy, read_data);
  endtask

  logic [2:0] load_f3  [5];
  logic [2:0] store_f3 [3];

  initial begin
    load_f3  = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    store_f3 = '{F3_SB, F3_SH, F3_SW};
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom();
      ref_mem[i] = mem[i];
    end
    reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_LW;
    address = 32'h100; write_data = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy_mis", {30'b0, busywait, misaligned}, 32'h0);
    check("rst_strobes", {30'b0, dmem_read, dmem_write}, 32'h0);
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_wdata", dmem_wdata, 32'h0);
    check("rst_byteen", {28'b0, dmem_byteen}, 32'h0);
    check("rst_rdata", read_data, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; mem_read = 1'b0;
    go_idle();

    // Directed cases
    do_access(1'b0, 1'b1, F3_SW, 32'h100, 32'hDEADBEEF, 2);
    check("sw_addr_c", dmem_addr, 32'h100);
    check("sw_be_c", {28'b0, dmem_byteen}, 32'hF);
    check("sw_wd_c", dmem_wdata, 32'hDEADBEEF);
    do_access(1'b0, 1'b1, F3_SW, 32'h100, 32'h80FF7F01, 1);
    do_access(1'b1, 1'b0, F3_LB, 32'h103, 32'h0, 1);
    check("lb103_c", read_data, 32'hFFFFFF80);
    do_access(1'b1, 1'b0, F3_LBU, 32'h103, 32'h0, 2);
    check("lbu103_c", read_data, 32'h00000080);
    do_access(1'b1, 1'b0, F3_LB, 32'h101, 32'h0, 1);
    check("lb101_c", read_data, 32'h0000007F);
    do_access(1'b0, 1'b1, F3_SW, 32'h100, 32'h80011234, 1);
    do_access(1'b1, 1'b0, F3_LH, 32'h102, 32'h0, 3);
    check("lh102_c", read_data, 32'hFFFF8001);
    do_access(1'b1, 1'b0, F3_LHU, 32'h102, 32'h0, 1);
    check("lhu102_c", read_data, 32'h00008001);
    do_access(1'b1, 1'b0, F3_LH, 32'h100, 32'h0, 1);
    check("lh100_c", read_data, 32'h00001234);
    do_access(1'b0, 1'b1, F3_SB, 32'h201, 32'h000000AB, 1);
    check("sb_addr_c", dmem_addr, 32'h200);
    check("sb_be_c", {28'b0, dmem_byteen}, 32'h2);
    check("sb_wd_c", dmem_wdata, 32'hABABABAB);
    do_access(1'b0, 1'b1, F3_SH, 32'h202, 32'h1234CDEF, 1);
    check("sh_be_c", {28'b0, dmem_byteen}, 32'hC);
    do_access(1'b1, 1'b0, F3_LW, 32'h102, 32'h0, 1);
    go_idle();

    // Reset in the second ACCESS cycle aborts the load
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = F3_LW; address = 32'h100; lat_cfg = 4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", {30'b0, busywait, misaligned}, 32'h0);
    @(negedge clk);
    check("rst_mid_strobe", {30'b0, dmem_read, dmem_write}, 32'h0);
    check("rst_mid_rdata", read_data, 32'h0);
    exp_rd = 32'h0;
    @(posedge clk); #1;
    reset = 1'b0; mem_read = 1'b0;
    go_idle();

    // Back-to-back loads with inputs held through DONE
    do_access(1'b1, 1'b0, F3_LW, 32'h100, 32'h0, 1);
    do_access(1'b1, 1'b0, F3_LW, 32'h200, 32'h0, 2);
    go_idle();

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      int          kind;
      logic        rd, wr;
      logic [2:0]  f3;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        go_idle();
      end else begin
        rd = (kind < 5) || (kind == 9);
        wr = !rd || (kind == 9);
        f3 = rd ? load_f3[$urandom_range(0, 4)] : store_f3[$urandom_range(0, 2)];
        do_access(rd, wr, f3, $urandom(), $urandom(), $urandom_range(1, 4));
        if ($urandom_range(0, 1) == 1) go_idle();
      end
    end
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
